// File: rtl/load_store_unit.sv
// load_store_unit: two-cycle load/store issue with byte-lane steering and load extension.
// Define LSU_MISALIGN_CHECK_EN to reject misaligned H/W accesses via lsu_misalign_o.
module load_store_unit (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [2:0]  lsu_size_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_data_i,
  output logic [31:0] lsu_data_o,
  output logic        lsu_stall_req_o,
`ifdef LSU_MISALIGN_CHECK_EN
  output logic        lsu_misalign_o,
`endif
  output logic        data_req_o,
  output logic        data_we_o,
  output logic [31:0] data_addr_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_wdata_o,
  input  logic [31:0] data_rdata_i
);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t state, state_nx;
  logic [2:0] size_q;
  logic [1:0] off_q;
  logic we_q;
  logic legal, misalign, go;
  logic [7:0] byte_v;
  logic [15:0] half_v;
  assign legal = (lsu_size_i[1:0] != 2'd3) && !(lsu_size_i[2] && lsu_size_i[1]);
`ifdef LSU_MISALIGN_CHECK_EN
  assign misalign = (lsu_size_i[1:0] == 2'd1 && lsu_addr_i[0]) ||
                    (lsu_size_i[1:0] == 2'd2 && lsu_addr_i[1:0] != 2'd0);
  assign lsu_misalign_o = !rst_i && state == IDLE && lsu_req_i && legal && misalign;
`else
  assign misalign = 1'b0;
`endif
  assign go = !rst_i && state == IDLE && lsu_req_i && legal && !misalign;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= IDLE;
      size_q <= '0;
      off_q  <= '0;
      we_q   <= 1'b0;
    end else begin
      state <= state_nx;
      if (go) begin
        size_q <= lsu_size_i;
        off_q  <= lsu_addr_i[1:0];
        we_q   <= lsu_we_i;
      end
    end
  end
  always_comb begin
    state_nx = go ? WAIT : IDLE;
  end
  always_comb begin
    data_req_o      = go;
    lsu_stall_req_o = go;
    data_we_o       = go && lsu_we_i;
    data_addr_o     = go ? {lsu_addr_i[31:2], 2'b00} : 32'd0;
    data_be_o       = !go ? 4'b0000 :
                      lsu_size_i[1:0] == 2'd0 ? 4'b0001 << lsu_addr_i[1:0] :
                      lsu_size_i[1:0] == 2'd1 ? (lsu_addr_i[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    data_wdata_o    = !go ? 32'd0 :
                      lsu_size_i[1:0] == 2'd0 ? {4{lsu_data_i[7:0]}} :
                      lsu_size_i[1:0] == 2'd1 ? {2{lsu_data_i[15:0]}} : lsu_data_i;
    byte_v          = data_rdata_i[{off_q, 3'b000} +: 8];
    half_v          = off_q[1] ? data_rdata_i[31:16] : data_rdata_i[15:0];
    lsu_data_o      = (rst_i || state != WAIT || we_q) ? 32'd0 :
                      size_q[1:0] == 2'd0 ? {{24{byte_v[7] & ~size_q[2]}}, byte_v} :
                      size_q[1:0] == 2'd1 ? {{16{half_v[15] & ~size_q[2]}}, half_v} : data_rdata_i;
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed scenarios plus randomized traffic against a byte-arithmetic model.
module tb_load_store_unit;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic lsu_req_i = 1'b0, lsu_we_i = 1'b0;
  logic [2:0] lsu_size_i = '0;
  logic [31:0] lsu_addr_i = '0, lsu_data_i = '0, data_rdata_i = '0;
  logic [31:0] lsu_data_o, data_addr_o, data_wdata_o;
  logic lsu_stall_req_o, data_req_o, data_we_o;
  logic [3:0] data_be_o;
`ifdef LSU_MISALIGN_CHECK_EN
  logic lsu_misalign_o;
`endif
  int n_cmp = 0, n_err = 0;
  always #5 clk_i = ~clk_i;
  load_store_unit dut (
    .clk_i(clk_i), .rst_i(rst_i), .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i),
    .lsu_size_i(lsu_size_i), .lsu_addr_i(lsu_addr_i), .lsu_data_i(lsu_data_i),
    .lsu_data_o(lsu_data_o), .lsu_stall_req_o(lsu_stall_req_o),
`ifdef LSU_MISALIGN_CHECK_EN
    .lsu_misalign_o(lsu_misalign_o),
`endif
    .data_req_o(data_req_o), .data_we_o(data_we_o), .data_addr_o(data_addr_o),
    .data_be_o(data_be_o), .data_wdata_o(data_wdata_o), .data_rdata_i(data_rdata_i)
  );
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask
  task automatic drive(input logic req, input logic we, input logic [2:0] size,
                       input logic [31:0] addr, input logic [31:0] data,
                       input logic [31:0] rdata, input logic rst);
    @(posedge clk_i);
    #1;
    lsu_req_i = req; lsu_we_i = we; lsu_size_i = size; lsu_addr_i = addr;
    lsu_data_i = data; data_rdata_i = rdata; rst_i = rst;
    #1;
  endtask
  function automatic int nbytes(input logic [2:0] s);
    return s[1:0] == 2'd0 ? 1 : s[1:0] == 2'd1 ? 2 : 4;
  endfunction
  function automatic int eff_off(input logic [2:0] s, input logic [1:0] off);
    int nb;
    nb = nbytes(s);
    return nb == 4 ? 0 : nb == 2 ? (int'(off) & 2) : int'(off);
  endfunction
  function automatic logic [31:0] exp_load(input logic [2:0] s, input logic [1:0] off, input logic [31:0] rd);
    logic [63:0] v, lim;
    int nb;
    nb  = nbytes(s);
    lim = 64'd1 << (8 * nb);
    v   = (64'(rd) >> (8 * eff_off(s, off))) % lim;
    if (!s[2] && v >= (lim >> 1)) v = v - lim;
    return v[31:0];
  endfunction
  function automatic logic [31:0] exp_be(input logic [2:0] s, input logic [1:0] off);
    return ((32'd1 << nbytes(s)) - 1) << eff_off(s, off);
  endfunction
  function automatic logic [31:0] exp_wdata(input logic [2:0] s, input logic [31:0] d);
    int nb;
    nb = nbytes(s);
    return nb == 1 ? (d % 256) * 32'h0101_0101 : nb == 2 ? (d % 65536) * 32'h0001_0001 : d;
  endfunction
  task automatic check_quiet(input string tag);
    check({tag, "_req"}, 32'(data_req_o), 0);
    check({tag, "_stall"}, 32'(lsu_stall_req_o), 0);
    check({tag, "_we"}, 32'(data_we_o), 0);
    check({tag, "_be"}, 32'(data_be_o), 0);
    check({tag, "_wdata"}, data_wdata_o, 0);
    check({tag, "_addr"}, data_addr_o, 0);
  endtask
  initial begin
    logic busy, p_we, issue, mis, legal;
    logic [2:0] p_size;
    logic [1:0] p_off;
    drive(1, 1, 2, 32'h1234, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
    check_quiet("rst");
    check("rst_ldata", lsu_data_o, 0);
    drive(0, 0, 0, 32'h0, 32'h0, 32'h0, 0);
    check_quiet("idle");
    check("idle_ldata", lsu_data_o, 0);
    drive(1, 0, 0, 32'h3, 32'h0, 32'h0, 0);
    check("lb_req", 32'(data_req_o), 1);
    check("lb_stall", 32'(lsu_stall_req_o), 1);
    check("lb_be", 32'(data_be_o), 32'h8);
    check("lb_addr", data_addr_o, 0);
    drive(1, 0, 0, 32'h3, 32'h0, 32'h80FF_1234, 0);
    check("lb_data", lsu_data_o, 32'hFFFF_FF80);
    check("lb_wait_req", 32'(data_req_o), 0);
    check("lb_wait_stall", 32'(lsu_stall_req_o), 0);
    drive(1, 0, 5, 32'h2, 32'h0, 32'h0, 0);
    check("lhu_be", 32'(data_be_o), 32'hC);
    drive(0, 0, 0, 32'h0, 32'h0, 32'h9ABC_0000, 0);
    check("lhu_data", lsu_data_o, 32'h0000_9ABC);
    drive(1, 0, 1, 32'h2, 32'h0, 32'h0, 0);
    drive(0, 0, 0, 32'h0, 32'h0, 32'h9ABC_0000, 0);
    check("lh_data", lsu_data_o, 32'hFFFF_9ABC);
    drive(1, 1, 0, 32'h801, 32'h0000_00A5, 32'h0, 0);
    check("sb_we", 32'(data_we_o), 1);
    check("sb_be", 32'(data_be_o), 32'h2);
    check("sb_wdata", data_wdata_o, 32'hA5A5_A5A5);
    check("sb_addr", data_addr_o, 32'h800);
    drive(0, 0, 0, 32'h0, 32'h0, 32'hDEAD_BEEF, 0);
    check("sb_wait_ldata", lsu_data_o, 0);
    for (int i = 0; i < 8; i++) begin
      drive(1, 1, 2, 32'h40 + 32'(4 * (i / 2)), 32'(i), 32'h0, 0);
      check($sformatf("b2b_req%0d", i), 32'(data_req_o), 32'((i + 1) % 2));
      check($sformatf("b2b_stall%0d", i), 32'(lsu_stall_req_o), 32'((i + 1) % 2));
    end
    drive(1, 0, 2, 32'h100, 32'h0, 32'h0, 0);
    check("lw_req", 32'(data_req_o), 1);
    drive(0, 0, 0, 32'h0, 32'h0, 32'h1111_2222, 1);
    check_quiet("abort");
    check("abort_ldata", lsu_data_o, 0);
    drive(0, 0, 0, 32'h0, 32'h0, 32'h1111_2222, 0);
    check("abort_after_ldata", lsu_data_o, 0);
    drive(1, 0, 3, 32'h0, 32'h0, 32'h0, 0);
    check("ill3_req", 32'(data_req_o), 0);
    check("ill3_stall", 32'(lsu_stall_req_o), 0);
    drive(1, 1, 7, 32'h0, 32'h0, 32'h0, 0);
    check("ill7_req", 32'(data_req_o), 0);
    drive(1, 0, 2, 32'h102, 32'h0, 32'h0, 0);
`ifdef LSU_MISALIGN_CHECK_EN
    check("mis_flag", 32'(lsu_misalign_o), 1);
    check("mis_req", 32'(data_req_o), 0);
    check("mis_stall", 32'(lsu_stall_req_o), 0);
`else
    check("lwu_req", 32'(data_req_o), 1);
    check("lwu_addr", data_addr_o, 32'h100);
    check("lwu_be", 32'(data_be_o), 32'hF);
    drive(0, 0, 0, 32'h0, 32'h0, 32'hCAFE_F00D, 0);
    check("lwu_data", lsu_data_o, 32'hCAFE_F00D);
`endif
    drive(0, 0, 0, 32'h0, 32'h0, 32'h0, 1);
    busy = 0; p_we = 0; p_size = 0; p_off = 0;
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)),
            $urandom, $urandom, $urandom, $urandom_range(0, 29) == 0);
      legal = lsu_size_i inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
      mis = 0;
`ifdef LSU_MISALIGN_CHECK_EN
      mis = (nbytes(lsu_size_i) == 2 && lsu_addr_i % 2 != 0) || (nbytes(lsu_size_i) == 4 && lsu_addr_i % 4 != 0);
      check("r_mis", 32'(lsu_misalign_o), 32'(!rst_i && !busy && lsu_req_i && legal && mis));
`endif
      issue = !rst_i && !busy && lsu_req_i && legal && !mis;
      check("r_req", 32'(data_req_o), 32'(issue));
      check("r_stall", 32'(lsu_stall_req_o), 32'(issue));
      check("r_we", 32'(data_we_o), 32'(issue && lsu_we_i));
      check("r_addr", data_addr_o, issue ? lsu_addr_i - lsu_addr_i % 4 : 0);
      check("r_be", 32'(data_be_o), issue ? exp_be(lsu_size_i, lsu_addr_i[1:0]) : 0);
      check("r_wdata", data_wdata_o, issue ? exp_wdata(lsu_size_i, lsu_data_i) : 0);
      check("r_ldata", lsu_data_o, (!rst_i && busy && !p_we) ? exp_load(p_size, p_off, data_rdata_i) : 0);
      if (issue) begin
        p_we = lsu_we_i; p_size = lsu_size_i; p_off = lsu_addr_i[1:0];
      end
      busy = issue;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
